// File: rtl/q3_ctrl_pkg.sv
// Shared definitions for the q3 stream controller: machine state codes,
// control FSM states and the Moore output decode.
package q3_ctrl_pkg;

  localparam logic [2:0] S0 = 3'd0;
  localparam logic [2:0] S1 = 3'd1;
  localparam logic [2:0] S2 = 3'd2;
  localparam logic [2:0] S3 = 3'd3;
  localparam logic [2:0] S4 = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_t;

  function automatic logic is_z(input logic [2:0] y);
    return (y == S3) || (y == S4);
  endfunction

endpackage

// File: rtl/q3_next_logic.sv
// Combinational next-state / output decode of the 5-state Moore machine;
// codes 5-7 are flagged illegal and steered back to S0.
module q3_next_logic
  import q3_ctrl_pkg::*;
(
  input  logic [2:0] i_y,
  input  logic       i_x,
  output logic [2:0] o_y_next,
  output logic       o_z,
  output logic       o_illegal
);

  always_comb begin
    o_y_next  = S0;
    o_illegal = 1'b0;
    case (i_y)
      S0:      o_y_next = i_x ? S1 : S0;
      S1:      o_y_next = i_x ? S4 : S1;
      S2:      o_y_next = i_x ? S1 : S2;
      S3:      o_y_next = i_x ? S2 : S1;
      S4:      o_y_next = i_x ? S4 : S3;
      default: o_illegal = 1'b1;
    endcase
  end

  assign o_z = is_z(i_y);

endmodule

// File: rtl/q3_stream_fsm_ctrl.sv
// Frame sequencer around the q3 Moore machine: valid/ready stream framing,
// z-run detection and illegal-state recovery. Optional Q3_HIT_COUNT_EN adds hit_count.
module q3_stream_fsm_ctrl
  import q3_ctrl_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned RUN_LEN   = 3,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             start,
  input  logic             x,
  input  logic             x_valid,
  output logic             x_ready,
  output logic [2:0]       y,
  output logic             z,
  output logic             hit,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef Q3_HIT_COUNT_EN
  ,
  output logic [CNT_W-1:0] hit_count
`endif
);

  localparam logic [CNT_W-1:0] LP_LAST_BIT = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] LP_RUN_MAX  = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] LP_RUN_PRE  = CNT_W'(RUN_LEN - 1);

  ctrl_state_t      r_ctrl;
  ctrl_state_t      w_ctrl_next;
  logic [2:0]       r_y;
  logic [2:0]       w_y_next;
  logic             w_z;
  logic             w_z_next;
  logic             w_illegal;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] r_run_cnt;
  logic             r_hit;
  logic             r_err;
  logic             w_accept;
  logic             w_start_frame;
  logic             w_last;
  logic             w_hit_set;

  q3_next_logic u_next (
    .i_y       (r_y),
    .i_x       (x),
    .o_y_next  (w_y_next),
    .o_z       (w_z),
    .o_illegal (w_illegal)
  );

  assign w_z_next      = is_z(w_y_next);
  assign w_accept      = x_valid & (r_ctrl == RUN);
  assign w_start_frame = start & (r_ctrl == IDLE);
  assign w_last        = w_accept & (r_bit_cnt == LP_LAST_BIT);
  // Fires only on the RUN_LEN-1 -> RUN_LEN step, so a saturated run never re-fires.
  assign w_hit_set     = ~w_start_frame & ~w_illegal & w_accept & w_z_next
                         & (r_run_cnt == LP_RUN_PRE);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_ctrl <= IDLE;
    end else begin
      r_ctrl <= w_ctrl_next;
    end
  end

  always_comb begin
    w_ctrl_next = r_ctrl;
    x_ready     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_ctrl)
      IDLE: begin
        if (start) w_ctrl_next = RUN;
      end
      RUN: begin
        x_ready = 1'b1;
        busy    = 1'b1;
        if (w_last) w_ctrl_next = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_ctrl_next = IDLE;
      end
      default: w_ctrl_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_y       <= S0;
      r_bit_cnt <= '0;
      r_run_cnt <= '0;
      r_hit     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_hit <= w_hit_set;
      if (w_start_frame) begin
        r_y       <= S0;
        r_bit_cnt <= '0;
        r_run_cnt <= '0;
        r_err     <= 1'b0;
      end else begin
        // An accept during an illegal-state cycle still counts as a frame bit.
        if (w_accept) r_bit_cnt <= r_bit_cnt + 1'b1;
        if (w_illegal) begin
          r_y       <= S0;
          r_err     <= 1'b1;
          r_run_cnt <= '0;
        end else if (w_accept) begin
          r_y <= w_y_next;
          if (!w_z_next) begin
            r_run_cnt <= '0;
          end else if (r_run_cnt != LP_RUN_MAX) begin
            r_run_cnt <= r_run_cnt + 1'b1;
          end
        end
      end
    end
  end

`ifdef Q3_HIT_COUNT_EN
  logic [CNT_W-1:0] r_hit_cnt;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_hit_cnt <= '0;
    end else if (w_start_frame) begin
      r_hit_cnt <= '0;
    end else if (w_hit_set && (r_hit_cnt != '1)) begin
      r_hit_cnt <= r_hit_cnt + 1'b1;
    end
  end

  assign hit_count = r_hit_cnt;
`endif

  assign y   = r_y;
  assign z   = w_z;
  assign hit = r_hit;
  assign err = r_err;

endmodule
